// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cnn_pkg : pixel/window types and the X_rc packing rule for the CNN stages  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cnn_pkg;
    localparam int PIX_W  = 8;
    localparam int KERNEL = 3;
    localparam int WIN_W  = PIX_W * KERNEL * KERNEL;

    typedef logic signed [PIX_W-1:0] pixel_t;
    typedef logic [WIN_W-1:0]        window_t;

    // LSB of X_rc (and W_rc in the convolution stage) inside a packed window.
    function automatic int win_lsb(input int r, input int c);
        return PIX_W * (KERNEL * r + c);
    endfunction
endpackage
`default_nettype wire

// File: rtl/cnn_line_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cnn_line_buffer_if : pixel stream in, 3x3 window stream out                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface cnn_line_buffer_if;
    import cnn_pkg::*;

    logic    in_valid;
    pixel_t  in_pixel;
    logic    out_valid;
    window_t out_window;
    logic    out_frame_done;

    modport master (
        output in_valid, in_pixel,
        input  out_valid, out_window, out_frame_done
    );

    modport slave (
        input  in_valid, in_pixel,
        output out_valid, out_window, out_frame_done
    );
endinterface
`default_nettype wire

// File: rtl/cnn_row_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cnn_row_fifo : DEPTH-entry shift buffer, dout is the pixel DEPTH accepts ago|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cnn_row_fifo
    import cnn_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic   clk,
    input  wire logic   shift,
    input  wire pixel_t din,
    output pixel_t      dout
);
    // Storage is deliberately left unreset; the caller gates stale contents.
    pixel_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (shift) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign dout = r_mem[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/cnn_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cnn_line_buffer : raster pixel stream to valid-only 3x3 sliding windows    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cnn_line_buffer
    import cnn_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input wire logic          clk,
    input wire logic          rst,
    cnn_line_buffer_if.slave  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_out_valid;
    logic          r_frame_done;
    pixel_t        r_win [KERNEL][KERNEL];

    logic   w_accept;
    logic   w_qualify;
    pixel_t w_tap1;
    pixel_t w_tap2;

    assign w_accept  = bus.in_valid && !rst;
    // Column gate stops row straddling; row gate stops frame straddling.
    assign w_qualify = (r_row >= RW'(2)) && (r_col >= CW'(2));

    cnn_row_fifo #(.DEPTH(IMG_W)) u_fifo_row1 (
        .clk   (clk),
        .shift (w_accept),
        .din   (bus.in_pixel),
        .dout  (w_tap1)
    );

    cnn_row_fifo #(.DEPTH(IMG_W)) u_fifo_row2 (
        .clk   (clk),
        .shift (w_accept),
        .din   (w_tap1),
        .dout  (w_tap2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= w_accept && w_qualify;
            r_frame_done <= w_accept && (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
            if (w_accept) begin
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Column 2 takes the new column (oldest row on top), older columns move left.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
            end
            r_win[0][2] <= w_tap2;
            r_win[1][2] <= w_tap1;
            r_win[2][2] <= bus.in_pixel;
        end
    end

    generate
        for (genvar gr = 0; gr < KERNEL; gr++) begin : g_win_row
            for (genvar gc = 0; gc < KERNEL; gc++) begin : g_win_col
                assign bus.out_window[win_lsb(gr, gc) +: PIX_W] = r_win[gr][gc];
            end
        end
    endgenerate

    assign bus.out_valid      = r_out_valid;
    assign bus.out_frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_cnn_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cnn_line_buffer : 4x4 and 8x8 instances on one stream, queue scoreboard |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cnn_line_buffer;
    typedef struct {
        logic [71:0] win;
        logic        fd;
        int          stamp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_pixel = 8'h00;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic rst_at_edge = 1'b0;

    int         dim   [2] = '{4, 8};
    int         mcol  [2];
    int         mrow  [2];
    logic [7:0] img   [2][8][8];
    exp_t       q0[$];
    exp_t       q1[$];
    logic [71:0] cap4[$];
    int cnt_v [2] = '{0, 0};
    int cnt_fd[2] = '{0, 0};
    int b_v   [2];
    int b_fd  [2];

    cnn_line_buffer_if bus4 ();
    cnn_line_buffer_if bus8 ();

    assign bus4.in_valid = in_valid;
    assign bus4.in_pixel = in_pixel;
    assign bus8.in_valid = in_valid;
    assign bus8.in_pixel = in_pixel;

    cnn_line_buffer #(.IMG_W(4), .IMG_H(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    cnn_line_buffer #(.IMG_W(8), .IMG_H(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;

    task automatic check_vec(input string nm, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference model: stores the current frame and cuts windows out of it.
    task automatic model_accept(input int d, input logic [7:0] p, input int stamp);
        exp_t e;
        int r0, c0;
        r0 = mrow[d];
        c0 = mcol[d];
        img[d][r0][c0] = p;
        if (r0 >= 2 && c0 >= 2) begin
            e.win = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.win[8*(3*r+c) +: 8] = img[d][r0-2+r][c0-2+c];
            e.fd    = (r0 == dim[d]-1) && (c0 == dim[d]-1);
            e.stamp = stamp;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        if (c0 == dim[d]-1) begin
            mcol[d] = 0;
            mrow[d] = (r0 == dim[d]-1) ? 0 : r0 + 1;
        end else begin
            mcol[d] = c0 + 1;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_at_edge = rst;
        if (rst) begin
            mcol = '{0, 0};
            mrow = '{0, 0};
        end else if (in_valid) begin
            for (int d = 0; d < 2; d++) model_accept(d, in_pixel, cyc);
        end
    end

    task automatic mon_dut(input int d, input logic ov, input logic [71:0] win, input logic fd);
        exp_t e;
        string nm;
        nm = (d == 0) ? "dut4" : "dut8";
        if (ov === 1'b1) begin
            cnt_v[d]++;
            if (fd === 1'b1) cnt_fd[d]++;
            if (d == 0) cap4.push_back(win);
            checks++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL %s_unexpected_window: got %h expected none", nm, win);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check_vec({nm, "_window"}, win, e.win);
                check_int({nm, "_frame_done"}, int'(fd), int'(e.fd));
                check_int({nm, "_latency_cycle"}, cyc, e.stamp);
            end
        end else if (fd === 1'b1) begin
            check_int({nm, "_stray_frame_done"}, 1, 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_at_edge) begin
            check_int("dut4_rst_out_valid", int'(bus4.out_valid), 0);
            check_int("dut4_rst_frame_done", int'(bus4.out_frame_done), 0);
            check_vec("dut4_rst_window", bus4.out_window, 72'h0);
            check_int("dut8_rst_out_valid", int'(bus8.out_valid), 0);
            check_vec("dut8_rst_window", bus8.out_window, 72'h0);
        end else begin
            mon_dut(0, bus4.out_valid, bus4.out_window, bus4.out_frame_done);
            mon_dut(1, bus8.out_valid, bus8.out_window, bus8.out_frame_done);
        end
    end

    // All stimulus tasks start and end at a falling edge.
    task automatic send(input logic [7:0] p, input int gap);
        in_valid = 1'b1;
        in_pixel = p;
        @(negedge clk);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_pixel = 8'h55;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_begin();
        pulse_reset();
        @(posedge clk);
        #1;
        b_v  = cnt_v;
        b_fd = cnt_fd;
        cap4.delete();
        @(negedge clk);
    endtask

    task automatic test_end(input string nm, input int ev4, input int efd4,
                            input int ev8, input int efd8);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        check_int({nm, "_windows4"}, cnt_v[0] - b_v[0], ev4);
        check_int({nm, "_frames4"},  cnt_fd[0] - b_fd[0], efd4);
        check_int({nm, "_windows8"}, cnt_v[1] - b_v[1], ev8);
        check_int({nm, "_frames8"},  cnt_fd[1] - b_fd[1], efd8);
        @(negedge clk);
    endtask

    task automatic check_cap(input string nm, input int idx, input logic [71:0] exp);
        if (cap4.size() > idx) check_vec(nm, cap4[idx], exp);
        else                   check_int({nm, "_missing"}, cap4.size(), idx + 1);
    endtask

    localparam logic [71:0] c_WIN_FIRST = 72'h0A_09_08_06_05_04_02_01_00;
    localparam logic [71:0] c_WIN_LAST  = 72'h0F_0E_0D_0B_0A_09_07_06_05;
    localparam logic [71:0] c_WIN_B     = 72'h6E_6D_6C_6A_69_68_66_65_64;
    localparam logic [71:0] c_WIN_SIGN  = 72'h7F_80_80_80_80_80_80_80_80;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic back-to-back frame.
        test_begin();
        for (int i = 0; i < 16; i++) send(8'(i), 0);
        test_end("basic", 4, 1, 0, 0);
        check_cap("basic_first", 0, c_WIN_FIRST);
        check_cap("basic_last", 3, c_WIN_LAST);

        // Three idle cycles between pixels.
        test_begin();
        for (int i = 0; i < 16; i++) send(8'(i), 3);
        test_end("gapped", 4, 1, 0, 0);
        check_cap("gapped_first", 0, c_WIN_FIRST);

        // Two frames with no gap between them.
        test_begin();
        for (int i = 0; i < 16; i++) send(8'(i), 0);
        for (int i = 0; i < 16; i++) send(8'(100 + i), 0);
        test_end("twoframes", 8, 2, 12, 0);
        check_cap("frameB_first", 4, c_WIN_B);

        // Reset after pixel 9 abandons the partial frame.
        test_begin();
        for (int i = 0; i < 10; i++) send(8'(i), 0);
        pulse_reset();
        for (int i = 0; i < 16; i++) send(8'(i), 0);
        test_end("midreset", 4, 1, 0, 0);
        check_cap("midreset_first", 0, c_WIN_FIRST);

        // Signed extremes pass bit-exact.
        test_begin();
        for (int i = 0; i < 16; i++) send((i == 10) ? 8'h7F : 8'h80, 0);
        test_end("signed", 4, 1, 0, 0);
        check_cap("signed_first", 0, c_WIN_SIGN);

        // Random 8x8 frame with random gaps.
        test_begin();
        for (int i = 0; i < 64; i++) send(8'($urandom), $urandom_range(0, 2));
        test_end("random", 16, 4, 36, 1);

        check_int("dut4_queue_drained", q0.size(), 0);
        check_int("dut8_queue_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cnn_line_buffer.md
CNN_LINE_BUFFER -- requirements
Module: cnn_line_buffer

Interface
REQ-001 Parameter IMG_W, default 8, pixels per image row; legal range 3..64.
REQ-002 Parameter IMG_H, default 8, rows per frame; legal range 3..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_pixel carries a valid pixel this cycle.
REQ-006 in_pixel  input  8  signed pixel, raster order (row-major, left to right, top to bottom).
REQ-007 out_valid  output  1  out_window holds a complete 3x3 window this cycle.
REQ-008 out_window  output  72  signed 8-bit X_rc packed at bits [8*(3r+c)+7 : 8*(3r+c)], r,c in 0..2.
REQ-009 out_frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-010 A pixel is accepted on every rising edge with in_valid=1 and rst=0; there is no backpressure, and in_valid gaps of any length are allowed.
REQ-011 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) track the position of the next pixel to be accepted; both advance only on acceptance.
REQ-012 col wraps from IMG_W-1 to 0 and increments row; row wraps from IMG_H-1 to 0, starting a new frame.
REQ-013 Two row buffers of IMG_W entries each hold the previous two rows; a 3x3 register window shifts one column left per accepted pixel.
REQ-014 For accepted pixel P(r,c): X_22=P(r,c), X_21=P(r,c-1), X_20=P(r,c-2), X_12=P(r-1,c), X_02=P(r-2,c); the rest follow the same pattern (X_00=P(r-2,c-2)).
REQ-015 out_valid is asserted in the cycle after accepting P(r,c) iff r>=2 and c>=2; otherwise it is 0.
REQ-016 Latency from acceptance to out_valid/out_window is exactly 1 cycle.
REQ-017 out_valid is a one-cycle pulse per qualifying pixel; it stays 0 during in_valid gaps.
REQ-018 out_window holds its last value when out_valid=0; its content is don't-care outside out_valid.
REQ-019 No padding: each frame produces exactly (IMG_W-2)*(IMG_H-2) windows.
REQ-020 Windows never straddle rows: pixels at c<2 are never combined with the previous row's tail.
REQ-021 Windows never straddle frames: rows of frame N are never combined with rows of frame N+1 (gated by row>=2 of the new frame).
REQ-022 out_frame_done pulses in the same cycle as the out_valid for P(IMG_H-1,IMG_W-1).
REQ-023 Pixel values pass through unmodified; sign is preserved, with no saturation and no rounding.

Reset
REQ-024 While rst=1: col=0, row=0, out_valid=0, out_frame_done=0, out_window=0.
REQ-025 in_valid is ignored in any cycle with rst=1.
REQ-026 A reset mid-frame discards the partial frame; the first accepted pixel after reset is P(0,0).
REQ-027 Row-buffer storage need not be cleared on reset; the counter gating in REQ-015 guarantees stale data is never output.

Structure
REQ-028 A shared package cnn_pkg holds PIX_W=8, KERNEL=3, WIN_W=PIX_W*KERNEL*KERNEL, plus the pack/index rule of REQ-008, for reuse by the convolution stage.
REQ-029 One sub-module, cnn_row_fifo (IMG_W-deep shift buffer advancing on accept), is instantiated twice in series.
REQ-030 out_window X_rc ordering matches the convolution stage's X_rc/W_rc port naming one-to-one.

Verification (IMG_W=4, IMG_H=4 unless stated)
REQ-031 Basic frame: pixels 0..15 streamed back-to-back -> 4 out_valid pulses. The first is 1 cycle after pixel 10, with X_00..X_22 = 0,1,2,4,5,6,8,9,10. The rest follow pixels 11, 14 and 15. out_frame_done coincides with the last pulse.
REQ-032 Gapped input: same frame with in_valid=0 for 3 cycles between every pixel -> identical 4 windows, each exactly 1 cycle after its pixel.
REQ-033 Back-to-back frames: frame A=0..15 then frame B=100..115 -> 8 windows total. B's first window is 1 cycle after pixel 110 and equals 100,101,102,104,105,106,108,109,110, with no frame-A value present.
REQ-034 Reset mid-frame: rst for 1 cycle after pixel 9, then pixels 0..15 -> no out_valid before the post-reset pixel 10; windows match REQ-031.
REQ-035 Signed values: frame of all -128 except P(2,2)=127 -> first window has X_22=127 and all other entries -128, bit-exact.
REQ-036 Default parameters (8x8), random pixels -> 36 windows, each equal to a reference-model slice; exactly one out_frame_done per frame.
